update_param: RTL and testbench



---
 rtl/update_param_if.sv | 56 +++++
 rtl/update_param.sv | 227 ++++++++++++++++++++++
 tb/tb_update_param.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/update_param_if.sv
// update_param frame/data input, read-base ROM port, stack push port
// and hit/retire reporting, grouped as one bundle.
interface update_param_if;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] position_in;
  logic [11:0] addr_in;
  logic [7:0] i_in;
  logic [7:0] z_in;
  logic [7:0] k_in;
  logic [7:0] l_in;
  logic [7:0] d_i_in;
  logic [7:0] C_in;
  logic [7:0] data_1_in;
  logic [7:0] data_2_in;
  logic       ce_rom_read;
  logic [7:0] addr_rom_read;
  logic [1:0] read_base;
  logic       push_valid;
  logic       push_ready;
  logic [7:0] push_i;
  logic [7:0] push_z;
  logic [7:0] push_k;
  logic [7:0] push_l;
  logic [4:0] push_position;
  logic       hit_valid;
  logic [7:0] hit_k;
  logic [7:0] hit_l;
  logic [11:0] hit_addr;
  logic       frame_done;
  logic       frame_pruned;

  modport slave (
    input  in_valid, position_in, addr_in,
    input  i_in, z_in, k_in, l_in,
    input  d_i_in, C_in, data_1_in, data_2_in,
    input  read_base, push_ready,
    output in_ready, ce_rom_read, addr_rom_read,
    output push_valid, push_i, push_z, push_k,
    output push_l, push_position,
    output hit_valid, hit_k, hit_l, hit_addr,
    output frame_done, frame_pruned
  );

  modport master (
    output in_valid, position_in, addr_in,
    output i_in, z_in, k_in, l_in,
    output d_i_in, C_in, data_1_in, data_2_in,
    output read_base, push_ready,
    input  in_ready, ce_rom_read, addr_rom_read,
    input  push_valid, push_i, push_z, push_k,
    input  push_l, push_position,
    input  hit_valid, hit_k, hit_l, hit_addr,
    input  frame_done, frame_pruned
  );
endinterface

// File: rtl/update_param.sv
// Inexact BWT backtracking update stage: consumes one stack frame,
// emits 0-3 successor frames, reports hits and frame retirement.
module update_param (
  input logic           clk,
  input logic           rst_n,
  update_param_if.slave bus
);

  // Position codes as laid out in config.v
  localparam logic [4:0] NONE  = 5'd0;
  localparam logic [4:0] A_DEL = 5'd1;
  localparam logic [4:0] A_INS = 5'd5;
  localparam logic [4:0] T_INS = 5'd8;

  typedef struct packed {
    logic [7:0] i;
    logic [7:0] z;
    logic [7:0] k;
    logic [7:0] l;
    logic [4:0] pos;
  } ent_t;

  typedef enum logic [2:0] {
    IDLE, DECIDE, RD, RDW,
    PUSH0, PUSH1, PUSH2, DONE
  } st_t;

  st_t         r_st;
  logic [4:0]  r_pos;
  logic [11:0] r_addr;
  logic [7:0]  r_i, r_z, r_k, r_l;
  logic [7:0]  r_di, r_kn, r_ln;
  ent_t        r_out, r_q1, r_q2;
  logic [1:0]  r_cnt;
  logic        r_rdy, r_pv, r_ce;
  logic [7:0]  r_ra;
  logic        r_hv, r_fd, r_fp;
  logic [7:0]  r_hk, r_hl;
  logic [11:0] r_ha;

  logic       w_none, w_is_ins;
  logic       w_prune, w_hit, w_fit;
  logic [4:0] w_boff;
  logic [1:0] w_b;
  logic       w_last;
  ent_t       w_c [0:3];
  logic [3:0] w_v;
  ent_t       w_q [0:3];
  logic [2:0] w_n;

  assign w_none   = (r_pos == NONE);
  assign w_is_ins = (r_pos >= A_INS) && (r_pos <= T_INS);
  assign w_prune  = (r_z < r_di);
  assign w_hit    = !w_prune && (r_i == 8'd0);
  assign w_fit    = (r_kn <= r_ln);
  assign w_boff   = r_pos - A_INS;
  assign w_b      = w_boff[1:0];

  always_comb begin
    w_c = '{default: '0};
    w_v = '0;
    unique case (1'b1)
      w_none: begin
        w_v[0] = !w_prune && (r_i != 8'd0);
        w_c[0] = {r_i, r_z, r_k, r_l, A_DEL};
      end
      (r_pos == A_DEL): begin
        w_v[0] = 1'b1;
        w_c[0] = {r_i, r_z, r_k, r_l, A_INS};
        w_v[1] = (r_z != 8'd0) && (r_i != 8'd0);
        w_c[1] = {r_i - 8'd1, r_z - 8'd1,
                  r_k, r_l, NONE};
      end
      w_is_ins: begin
        w_v[0] = (r_pos != T_INS);
        w_c[0] = {r_i, r_z, r_k, r_l, r_pos + 5'd1};
        w_v[1] = w_fit && (r_z != 8'd0);
        w_c[1] = {r_i, r_z - 8'd1, r_kn, r_ln, NONE};
        w_v[2] = w_fit && (w_b == bus.read_base)
                 && (r_i != 8'd0);
        w_c[2] = {r_i - 8'd1, r_z, r_kn, r_ln, NONE};
        w_v[3] = w_fit && (w_b != bus.read_base)
                 && (r_z != 8'd0) && (r_i != 8'd0);
        w_c[3] = {r_i - 8'd1, r_z - 8'd1,
                  r_kn, r_ln, NONE};
      end
      default: ;
    endcase
  end

  // Compact the valid candidates so push states never see holes
  always_comb begin
    w_n = '0;
    w_q = '{default: '0};
    for (int j = 0; j < 4; j++) begin
      if (w_v[j]) begin
        w_q[w_n[1:0]] = w_c[j];
        w_n = w_n + 3'd1;
      end
    end
  end

  assign w_last = (r_st == PUSH2) ||
                  ((r_st == PUSH1) && (r_cnt == 2'd2)) ||
                  ((r_st == PUSH0) && (r_cnt == 2'd1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_st   <= IDLE;
      r_pos  <= '0;
      r_addr <= '0;
      r_i    <= '0;
      r_z    <= '0;
      r_k    <= '0;
      r_l    <= '0;
      r_di   <= '0;
      r_kn   <= '0;
      r_ln   <= '0;
      r_out  <= '0;
      r_q1   <= '0;
      r_q2   <= '0;
      r_cnt  <= '0;
      r_rdy  <= 1'b0;
      r_pv   <= 1'b0;
      r_ce   <= 1'b0;
      r_ra   <= '0;
      r_hv   <= 1'b0;
      r_hk   <= '0;
      r_hl   <= '0;
      r_ha   <= '0;
      r_fd   <= 1'b0;
      r_fp   <= 1'b0;
    end else begin
      r_fd <= 1'b0;
      r_fp <= 1'b0;
      r_hv <= 1'b0;
      r_hk <= '0;
      r_hl <= '0;
      r_ha <= '0;
      unique case (r_st)
        IDLE: begin
          r_rdy <= 1'b1;
          if (r_rdy && bus.in_valid) begin
            r_rdy  <= 1'b0;
            r_pos  <= bus.position_in;
            r_addr <= bus.addr_in;
            r_i    <= bus.i_in;
            r_z    <= bus.z_in;
            r_k    <= bus.k_in;
            r_l    <= bus.l_in;
            r_di   <= bus.d_i_in;
            r_kn   <= bus.C_in + bus.data_1_in + 8'd1;
            r_ln   <= bus.C_in + bus.data_2_in;
            r_st   <= DECIDE;
          end
        end
        DECIDE, RDW: begin
          if ((r_st == DECIDE) && w_is_ins) begin
            r_ce <= 1'b1;
            r_ra <= (r_i != 8'd0) ? r_i - 8'd1 : 8'd0;
            r_st <= RD;
          end else if (w_n != 3'd0) begin
            r_out <= w_q[0];
            r_q1  <= w_q[1];
            r_q2  <= w_q[2];
            r_cnt <= w_n[1:0];
            r_pv  <= 1'b1;
            r_st  <= PUSH0;
          end else begin
            r_fd <= 1'b1;
            r_fp <= w_none && w_prune;
            if (w_none && w_hit) begin
              r_hv <= 1'b1;
              r_hk <= r_k;
              r_hl <= r_l;
              r_ha <= r_addr;
            end
            r_st <= DONE;
          end
        end
        RD: begin
          r_ce <= 1'b0;
          r_ra <= '0;
          r_st <= RDW;
        end
        PUSH0, PUSH1, PUSH2: begin
          if (bus.push_ready) begin
            if (w_last) begin
              r_pv  <= 1'b0;
              r_out <= '0;
              r_fd  <= 1'b1;
              r_st  <= DONE;
            end else if (r_st == PUSH0) begin
              r_out <= r_q1;
              r_st  <= PUSH1;
            end else begin
              r_out <= r_q2;
              r_st  <= PUSH2;
            end
          end
        end
        DONE: begin
          r_rdy <= 1'b1;
          r_st  <= IDLE;
        end
        default: r_st <= IDLE;
      endcase
    end
  end

  assign bus.in_ready      = r_rdy;
  assign bus.ce_rom_read   = r_ce;
  assign bus.addr_rom_read = r_ra;
  assign bus.push_valid    = r_pv;
  assign bus.push_i        = r_out.i;
  assign bus.push_z        = r_out.z;
  assign bus.push_k        = r_out.k;
  assign bus.push_l        = r_out.l;
  assign bus.push_position = r_out.pos;
  assign bus.hit_valid     = r_hv;
  assign bus.hit_k         = r_hk;
  assign bus.hit_l         = r_hl;
  assign bus.hit_addr      = r_ha;
  assign bus.frame_done    = r_fd;
  assign bus.frame_pruned  = r_fp;

endmodule

// File: tb/tb_update_param.sv
// Scoreboard bench for update_param: random and directed frames
// checked against a search-rule reference model.
module tb_update_param;

  localparam logic [4:0] NONE   = 5'd0;
  localparam logic [4:0] A_DEL  = 5'd1;
  localparam logic [4:0] A_INS  = 5'd5;
  localparam logic [4:0] C_INS  = 5'd6;
  localparam logic [4:0] T_INS  = 5'd8;

  typedef struct packed {
    logic [7:0] i;
    logic [7:0] z;
    logic [7:0] k;
    logic [7:0] l;
    logic [4:0] pos;
  } ent_t;

  typedef struct {
    int          npush;
    int          first;
    bit          pruned;
    bit          hit;
    logic [7:0]  k;
    logic [7:0]  l;
    logic [11:0] addr;
  } done_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   pr_mode;
  logic [1:0] rom [0:255];

  ent_t       exp_push [$];
  done_t      exp_done [$];
  logic [7:0] exp_addr [$];

  update_param_if bus ();

  update_param dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.ce_rom_read) bus.read_base <= rom[bus.addr_rom_read];

  always @(posedge clk) begin
    #1;
    case (pr_mode)
      0: bus.push_ready = 1'b1;
      1: bus.push_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s got=event exp=none", nm);
  endtask

  function automatic ent_t mk(input int i, z, k, l,
                              input logic [4:0] p);
    ent_t e;
    e.i = 8'(i);
    e.z = 8'(z);
    e.k = 8'(k);
    e.l = 8'(l);
    e.pos = p;
    return e;
  endfunction

  function automatic ent_t cur_push();
    return {bus.push_i, bus.push_z, bus.push_k,
            bus.push_l, bus.push_position};
  endfunction

  task automatic expect_frame(input logic [4:0] pos,
                              input int i, z, k, l, addr,
                              input int di, c, d1, d2);
    done_t d;
    int kn, ln, b, rb, ra, n;
    n = 0;
    d.first = 2;
    d.pruned = 0;
    d.hit = 0;
    d.k = 0;
    d.l = 0;
    d.addr = 0;
    if (pos == NONE) begin
      if (z < di) d.pruned = 1;
      else if (i == 0) begin
        d.hit = 1;
        d.k = 8'(k);
        d.l = 8'(l);
        d.addr = 12'(addr);
      end else begin
        exp_push.push_back(mk(i, z, k, l, A_DEL));
        n++;
      end
    end else if (pos == A_DEL) begin
      exp_push.push_back(mk(i, z, k, l, A_INS));
      n++;
      if (z > 0 && i > 0) begin
        exp_push.push_back(mk(i - 1, z - 1, k, l, NONE));
        n++;
      end
    end else if (pos >= A_INS && pos <= T_INS) begin
      d.first = 4;
      b = int'(pos) - int'(A_INS);
      kn = (c + d1 + 1) % 256;
      ln = (c + d2) % 256;
      ra = (i > 0) ? i - 1 : 0;
      exp_addr.push_back(8'(ra));
      rb = int'(rom[ra]);
      if (b < 3) begin
        exp_push.push_back(mk(i, z, k, l, pos + 5'd1));
        n++;
      end
      if (kn <= ln) begin
        if (z > 0) begin
          exp_push.push_back(mk(i, z - 1, kn, ln, NONE));
          n++;
        end
        if (b == rb) begin
          if (i > 0) begin
            exp_push.push_back(mk(i - 1, z, kn, ln, NONE));
            n++;
          end
        end else if (z > 0 && i > 0) begin
          exp_push.push_back(mk(i - 1, z - 1, kn, ln, NONE));
          n++;
        end
      end
    end
    d.npush = n;
    exp_done.push_back(d);
  endtask

  task automatic send(input logic [4:0] pos,
                      input int i, z, k, l, addr,
                      input int di, c, d1, d2);
    int t;
    expect_frame(pos, i, z, k, l, addr, di, c, d1, d2);
    @(posedge clk);
    #1;
    bus.position_in = pos;
    bus.i_in = 8'(i);
    bus.z_in = 8'(z);
    bus.k_in = 8'(k);
    bus.l_in = 8'(l);
    bus.addr_in = 12'(addr);
    bus.d_i_in = 8'(di);
    bus.C_in = 8'(c);
    bus.data_1_in = 8'(d1);
    bus.data_2_in = 8'(d2);
    bus.in_valid = 1'b1;
    t = 0;
    while (t < 500) begin
      @(negedge clk);
      if (bus.in_ready) break;
      t++;
    end
    if (t >= 500) fail("accept_timeout");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.i_in = 8'($urandom);
    bus.z_in = 8'($urandom);
    bus.d_i_in = 8'($urandom);
    bus.C_in = 8'($urandom);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (exp_done.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (exp_done.size() != 0) fail("idle_timeout");
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_a"}, {bus.in_ready, bus.ce_rom_read,
        bus.addr_rom_read, bus.push_valid, bus.push_i,
        bus.push_z, bus.push_k, bus.push_l,
        bus.push_position}, 64'd0);
    chk({nm, "_b"}, {bus.hit_valid, bus.hit_k, bus.hit_l,
        bus.hit_addr, bus.frame_done,
        bus.frame_pruned}, 64'd0);
  endtask

  // Monitor / scoreboard
  int    cyc, stalls, pcount;
  bit    in_flight, stall_prev, seen_push;
  ent_t  prev_out;
  done_t dd;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_flight = 0;
      stall_prev = 0;
      exp_push.delete();
      exp_done.delete();
      exp_addr.delete();
    end else begin
      if (in_flight) begin
        cyc++;
        chk("in_ready_busy", bus.in_ready, 0);
      end
      if (bus.ce_rom_read) begin
        if (exp_addr.size() == 0) fail("rom_unexpected");
        else begin
          chk("rom_addr", bus.addr_rom_read,
              exp_addr.pop_front());
          chk("rom_latency", cyc, 2);
        end
      end
      if (bus.push_valid) begin
        if (!in_flight || exp_done.size() == 0)
          fail("push_unexpected");
        else begin
          if (stall_prev)
            chk("push_stable", cur_push(), prev_out);
          if (!seen_push) begin
            chk("push_latency", cyc, exp_done[0].first);
            seen_push = 1;
          end
          if (bus.push_ready) begin
            if (exp_push.size() == 0) fail("push_extra");
            else chk("push_entry", cur_push(),
                     exp_push.pop_front());
            pcount++;
            stall_prev = 0;
          end else begin
            stalls++;
            stall_prev = 1;
            prev_out = cur_push();
          end
        end
      end
      if (bus.frame_done) begin
        if (!in_flight || exp_done.size() == 0)
          fail("done_unexpected");
        else begin
          dd = exp_done.pop_front();
          chk("pruned", bus.frame_pruned, dd.pruned);
          chk("hit_valid", bus.hit_valid, dd.hit);
          if (dd.hit)
            chk("hit_fields",
                {bus.hit_k, bus.hit_l, bus.hit_addr},
                {dd.k, dd.l, dd.addr});
          chk("push_count", pcount, dd.npush);
          chk("done_latency", cyc, (dd.npush == 0) ?
              dd.first : dd.first + dd.npush + stalls);
          in_flight = 0;
        end
      end else if (bus.hit_valid) begin
        fail("hit_without_done");
      end
      if (bus.in_valid && bus.in_ready) begin
        in_flight = 1;
        cyc = 0;
        stalls = 0;
        pcount = 0;
        seen_push = 0;
        stall_prev = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [4:0] p;
    int r, i, z, d1, d2;
    checks = 0;
    failures = 0;
    pr_mode = 2;
    for (int j = 0; j < 256; j++)
      rom[j] = 2'($urandom_range(0, 3));
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.position_in = '0;
    bus.addr_in = '0;
    bus.i_in = '0;
    bus.z_in = '0;
    bus.k_in = '0;
    bus.l_in = '0;
    bus.d_i_in = '0;
    bus.C_in = '0;
    bus.data_1_in = '0;
    bus.data_2_in = '0;
    bus.read_base = '0;
    bus.push_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset_state");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pr_mode = 0;
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_reset", bus.in_ready, 1);

    send(NONE, 5, 1, 0, 0, 0, 2, 0, 0, 0);
    wait_idle();
    send(NONE, 0, 1, 3, 7, 12'h00A, 0, 0, 0, 0);
    wait_idle();
    send(A_DEL, 4, 1, 2, 9, 12'h011, 0, 0, 0, 0);
    wait_idle();
    send(A_DEL, 4, 0, 2, 9, 12'h012, 0, 0, 0, 0);
    wait_idle();
    rom[3] = 2'd1;
    send(C_INS, 4, 1, 20, 30, 12'h013, 0, 10, 2, 5);
    wait_idle();
    send(T_INS, 4, 1, 20, 30, 12'h014, 0, 10, 5, 5);
    wait_idle();

    pr_mode = 2;
    bus.push_ready = 1'b0;
    send(NONE, 6, 2, 1, 8, 12'h015, 1, 0, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    bus.push_ready = 1'b1;
    wait_idle();

    bus.push_ready = 1'b0;
    send(A_DEL, 4, 1, 2, 9, 12'h016, 0, 0, 0, 0);
    t = 0;
    while (!bus.push_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) fail("push_wait_timeout");
    @(posedge clk);
    #1;
    bus.push_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.push_ready = 1'b0;
    @(negedge clk);
    chk("push1_pending", bus.push_valid, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_zero("mid_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pr_mode = 0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_reset_no_done", bus.frame_done, 0);

    pr_mode = 1;
    repeat (300) begin
      r = $urandom_range(0, 11);
      if (r <= 2) p = NONE;
      else if (r <= 4) p = A_DEL;
      else if (r <= 8) p = 5'(int'(A_INS) + r - 5);
      else begin
        p = 5'($urandom_range(2, 31));
        if (p >= A_INS && p <= T_INS) p = p + 5'd4;
      end
      i = (p == NONE) ? $urandom_range(0, 6)
                      : $urandom_range(1, 20);
      z = $urandom_range(0, 3);
      d1 = $urandom_range(0, 255);
      d2 = ($urandom_range(0, 1) == 1)
           ? d1 + $urandom_range(0, 3)
           : $urandom_range(0, 255);
      send(p, i, z, $urandom_range(0, 255),
           $urandom_range(0, 255), $urandom_range(0, 4095),
           $urandom_range(0, 3), $urandom_range(0, 255),
           d1, d2 % 256);
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    pr_mode = 0;
    wait_idle();
    chk("push_queue_drained", exp_push.size(), 0);
    chk("addr_queue_drained", exp_addr.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
